neuron_mac: RTL and testbench

Single-neuron multiply-accumulate engine that sits directly downstream of one per-neuron weight RAM (registered read, 1-cycle latency, output held while read enable is low). On start it streams weights out of that RAM by address and consumes one activation per cycle over a valid/ready handshake. It accumulates the signed fixed-point dot product, adds the bias, rescales, saturates and optionally applies ReLU. The neuron output is presented on a valid/ready output port for the next layer.

---
 rtl/neuron_mac.sv | 132 +++++++++++++
 tb/tb_neuron_mac.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// Single-neuron MAC: streams weights from a registered-read RAM, accumulates the
// fixed-point dot product with incoming activations, then adds bias, rescales, saturates and applies ReLU.
module neuron_mac #(
  parameter int numWeights   = 16,
  parameter int addressWidth = 4,
  parameter int dataWidth    = 16,
  parameter int fracBits     = 8,
  parameter bit reluEn       = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [dataWidth-1:0]    bias,
  input  logic                    in_valid,
  input  logic [dataWidth-1:0]    in_data,
  output logic                    in_ready,
  output logic                    w_readEn,
  output logic [addressWidth-1:0] w_addr,
  input  logic [dataWidth-1:0]    w_data,
  output logic                    out_valid,
  output logic [dataWidth-1:0]    out_data,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int PROD_W = 2 * dataWidth;
  localparam int ACC_W  = 2 * dataWidth + addressWidth;
  localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeights - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - dataWidth + 1){1'b0}}, {(dataWidth - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - dataWidth + 1){1'b1}}, {(dataWidth - 1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PRIME, MAC, BIAS, OUT} state_t;

  state_t                         state_q, state_d;
  logic [addressWidth-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic signed [dataWidth-1:0]    bias_q, bias_d;
  logic [dataWidth-1:0]           out_data_q, out_data_d;

  logic signed [PROD_W-1:0]       prod;
  logic signed [ACC_W-1:0]        prod_ext;
  logic signed [ACC_W-1:0]        bias_ext;
  logic signed [ACC_W-1:0]        sum;
  logic signed [ACC_W-1:0]        scaled;

  function automatic logic signed [dataWidth-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[dataWidth-1:0];
    if (v < SAT_MIN) return SAT_MIN[dataWidth-1:0];
    return v[dataWidth-1:0];
  endfunction

  function automatic logic signed [dataWidth-1:0] relu(input logic signed [dataWidth-1:0] v);
    if (reluEn && v[dataWidth-1]) return '0;
    return v;
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    bias_d     = bias_q;
    out_data_d = out_data_q;
    w_readEn   = 1'b0;
    w_addr     = '0;

    prod     = $signed(in_data) * $signed(w_data);
    prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    bias_ext = {{(ACC_W - dataWidth){bias_q[dataWidth-1]}}, bias_q};
    // bias is aligned to the product's 2*fracBits scale before the floor shift
    sum      = acc_q + (bias_ext <<< fracBits);
    scaled   = sum >>> fracBits;

    case (state_q)
      IDLE: begin
        if (start) begin
          bias_d   = bias;
          idx_d    = '0;
          acc_d    = '0;
          w_readEn = 1'b1;
          w_addr   = '0;
          state_d  = PRIME;
        end
      end
      PRIME: state_d = MAC;
      MAC: begin
        if (in_valid) begin
          acc_d = acc_q + prod_ext;
          if (idx_q == LAST_IDX) begin
            state_d = BIAS;
          end else begin
            // next weight is fetched in the accepting cycle to sustain one activation per clock
            idx_d    = idx_q + addressWidth'(1);
            w_readEn = 1'b1;
            w_addr   = idx_q + addressWidth'(1);
          end
        end
      end
      BIAS: begin
        out_data_d = relu(saturate(scaled));
        state_d    = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      bias_q     <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      bias_q     <= bias_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == MAC);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: two instances (ReLU off / on) share stimulus,
// each fed by its own registered-read weight RAM model.
module tb_neuron_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, in_valid, out_ready;
  logic [15:0] bias, in_data;

  logic        in_ready_a, w_readEn_a, out_valid_a, busy_a;
  logic [3:0]  w_addr_a;
  logic [15:0] w_data_a, out_data_a;
  logic        in_ready_b, w_readEn_b, out_valid_b, busy_b;
  logic [3:0]  w_addr_b;
  logic [15:0] w_data_b, out_data_b;

  logic [15:0] wmem [16];
  logic [15:0] act  [16];

  int n_checks = 0;
  int n_fail   = 0;

  neuron_mac #(.reluEn(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .w_readEn(w_readEn_a), .w_addr(w_addr_a), .w_data(w_data_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready),
    .busy(busy_a)
  );

  neuron_mac #(.reluEn(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .w_readEn(w_readEn_b), .w_addr(w_addr_b), .w_data(w_data_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready),
    .busy(busy_b)
  );

  always_ff @(posedge clk) if (w_readEn_a) w_data_a <= wmem[w_addr_a];
  always_ff @(posedge clk) if (w_readEn_b) w_data_b <= wmem[w_addr_b];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] a);
    for (int i = 0; i < 16; i++) begin
      wmem[i] = i[0] ? w1 : w0;
      act[i]  = a;
    end
  endtask

  // Entered 1 time unit after a rising edge; leaves at the same phase in the first MAC cycle.
  task automatic do_start(input logic [15:0] b);
    bias  = b;
    start = 1'b1;
    #1;
    chk("start_rd", {w_readEn_a, w_addr_a, w_readEn_b, w_addr_b}, {1'b1, 4'h0, 1'b1, 4'h0});
    @(posedge clk); #1;
    start = 1'b0;
    chk("prime", {in_ready_a, in_ready_b, busy_a, busy_b, w_readEn_a, w_readEn_b}, 6'b001100);
    @(posedge clk); #1;
  endtask

  task automatic feed(input int n, input bit gaps);
    int i   = 0;
    int cyc = 0;
    while (i < n) begin
      if (cyc > 200) begin
        chk("feed_timeout", 64'(i), 64'(n));
        break;
      end
      cyc++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        #1;
        chk("stall_rd", {w_readEn_a, w_readEn_b, in_ready_a, in_ready_b}, 4'b0011);
        @(posedge clk); #1;
      end else begin
        in_valid = 1'b1;
        in_data  = act[i];
        #1;
        if (i < 15)
          chk("hs_rd", {w_readEn_a, w_addr_a, w_readEn_b, w_addr_b, in_ready_a, in_ready_b},
              {1'b1, 4'(i + 1), 1'b1, 4'(i + 1), 2'b11});
        else
          chk("last_rd", {w_readEn_a, w_readEn_b, in_ready_a, in_ready_b}, 4'b0011);
        @(posedge clk); #1;
        i++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_out(input logic [15:0] ea, input logic [15:0] eb, input int hold,
                            input string tag);
    chk({tag, "_bias"}, {out_valid_a, out_valid_b, busy_a, busy_b, in_ready_a, in_ready_b}, 6'b001100);
    @(posedge clk); #1;
    chk({tag, "_a"}, {out_valid_a, out_data_a}, {1'b1, ea});
    chk({tag, "_b"}, {out_valid_b, out_data_b}, {1'b1, eb});
    for (int k = 0; k < hold; k++) begin
      if (k == 3) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_hold"}, {out_valid_a, out_data_a, out_valid_b, out_data_b, busy_a, busy_b},
          {1'b1, ea, 1'b1, eb, 2'b11});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_done"}, {out_valid_a, busy_a, out_data_a, out_valid_b, busy_b, out_data_b},
        {2'b00, ea, 2'b00, eb});
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {in_ready_a, out_valid_a, out_data_a, w_readEn_a, w_addr_a, busy_a,
              in_ready_b, out_valid_b, out_data_b, w_readEn_b, w_addr_b, busy_b}, 64'h0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bias      = '0;
    in_data   = '0;
    fill(16'h0100, 16'h0100, 16'h0100);
    #2;
    chk_zero("reset");
    #20;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // unit weights and inputs: 16 * 1.0
    fill(16'h0100, 16'h0100, 16'h0100);
    do_start(16'h0000);
    feed(16, 1'b0);
    finish_out(16'h1000, 16'h1000, 0, "t1");

    // alternating 2.0 / -1.0 weights, bias 0.5
    fill(16'h0200, 16'hFF00, 16'h0100);
    do_start(16'h0080);
    feed(16, 1'b0);
    finish_out(16'h0880, 16'h0880, 0, "t2");

    // same with input gaps; out_ready raised early has no effect before out_valid
    out_ready = 1'b1;
    do_start(16'h0080);
    feed(16, 1'b1);
    finish_out(16'h0880, 16'h0880, 0, "t2g");

    // saturation both ways
    fill(16'h7FFF, 16'h7FFF, 16'h7FFF);
    do_start(16'h0000);
    feed(16, 1'b0);
    finish_out(16'h7FFF, 16'h7FFF, 0, "t3p");

    fill(16'h8001, 16'h8001, 16'h7FFF);
    do_start(16'h0000);
    feed(16, 1'b0);
    finish_out(16'h8000, 16'h0000, 0, "t3n");

    // output backpressure with an ignored start during OUT
    fill(16'h0100, 16'h0100, 16'h0100);
    do_start(16'h0000);
    feed(16, 1'b0);
    finish_out(16'h1000, 16'h1000, 10, "t4");

    // asynchronous reset in the middle of a dot product
    fill(16'h0200, 16'h0200, 16'h0100);
    do_start(16'h0000);
    feed(7, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("t5_rst");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_idle", {busy_a, busy_b, out_valid_a, out_valid_b}, 4'b0000);
    fill(16'h0100, 16'h0100, 16'h0100);
    do_start(16'h0000);
    feed(16, 1'b0);
    finish_out(16'h1000, 16'h1000, 0, "t5");

    // floor rounding of tiny sums
    fill(16'h0001, 16'h0001, 16'h0001);
    do_start(16'h0000);
    feed(16, 1'b0);
    finish_out(16'h0000, 16'h0000, 0, "t6p");

    fill(16'h0001, 16'h0001, 16'hFFFF);
    do_start(16'h0000);
    feed(16, 1'b0);
    finish_out(16'hFFFF, 16'h0000, 0, "t6n");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
